// File: rtl/apb_bridge_nslv.sv
// Request/response to APB bridge fanning out to NUM_SLAVES completers.
// The slave index is decoded from an address field; out-of-range indices get a local decode error.
module apb_bridge_nslv #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic [1:0]                       dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [IDX_W-1:0]        req_idx;
    logic                    req_idx_ok;
    logic                    sel_ready;
    logic                    sel_slverr;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    timeout_hit;

    // Handshake: a request transfers on the edge where req_valid && req_ready; req_ready is high
    // only in IDLE. The response is a single-cycle rsp_valid pulse with no backpressure.
    assign req_ready  = (state_q == IDLE);
    assign req_idx    = req_addr[SEL_LSB +: IDX_W];
    assign req_idx_ok = (int'(req_idx) < NUM_SLAVES);

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

    // Only the completer currently selected is observed; the rest are don't-care.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) begin
                sel_ready  = PREADY[i];
                sel_slverr = PSLVERR[i];
                sel_rdata  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pstrb_d  = req_write ? req_strb : '0;
                    pwrite_d = req_write;
                    for (int i = 0; i < NUM_SLAVES; i++) begin
                        psel_d[i] = req_idx_ok && (int'(req_idx) == i);
                    end
                    if (req_idx_ok) begin
                        state_d = SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready completer takes priority over a timeout landing in the same cycle.
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_slverr;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                    state_d     = IDLE;
                end else if (timeout_hit) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DECERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dbg_state = state_q;
endmodule

// File: doc/apb_bridge_nslv.md
APB_BRIDGE_NSLV -- requirements
Module: apb_bridge_nslv

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width, multiple of 8; STRB_W = DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 4, range 1..16, number of APB completers.
REQ-004 SHALL have parameter SEL_LSB, default 12, LSB of slave-index field; index = addr[SEL_LSB +: max(1,clog2(NUM_SLAVES))].
REQ-005 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles before forced error; 0 disables timeout.
REQ-006 SHALL have PCLK  input  1  sole clock, rising edge.
REQ-007 SHALL have PRESET  input  1  synchronous, active-high reset.
REQ-008 SHALL have req_valid/req_ready  in/out  1/1  request handshake.
REQ-009 SHALL have req_write  in  1, req_addr  in  ADDR_WIDTH, req_wdata  in  DATA_WIDTH, req_strb  in  STRB_W  request payload.
REQ-010 SHALL have rsp_valid  out  1, rsp_rdata  out  DATA_WIDTH, rsp_err  out  1  one-cycle response.
REQ-011 SHALL have PSEL  out  NUM_SLAVES  one-hot completer select.
REQ-012 SHALL have PENABLE, PWRITE  out  1, PADDR  out  ADDR_WIDTH, PWDATA  out  DATA_WIDTH, PSTRB  out  STRB_W.
REQ-013 SHALL have PRDATA  in  NUM_SLAVES*DATA_WIDTH (slave i at [i*DATA_WIDTH +: DATA_WIDTH]), PREADY  in  NUM_SLAVES, PSLVERR  in  NUM_SLAVES.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS, DECERR; all APB and rsp outputs registered.
REQ-015 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid&&req_ready.
REQ-016 SHALL, on accept, latch addr/wdata/strb/write into PADDR/PWDATA/PSTRB/PWRITE, held stable until return to IDLE.
REQ-017 SHALL force PSTRB=0 for reads.
REQ-018 SHALL, on accept with index < NUM_SLAVES, enter SETUP: PSEL[index]=1, PENABLE=0.
REQ-019 SHALL, on accept with index >= NUM_SLAVES, enter DECERR: no PSEL bit asserted; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-020 SHALL move SETUP->ACCESS unconditionally after one cycle, PENABLE=1, PSEL held.
REQ-021 SHALL sample only the selected slave's PREADY/PSLVERR/PRDATA in ACCESS; other slaves' inputs ignored.
REQ-022 SHALL, in ACCESS with selected PREADY=1, next cycle: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=PSLVERR[index], rsp_rdata=PRDATA slice for reads (0 for writes), state IDLE.
REQ-023 SHALL count ACCESS cycles with PREADY=0; when count reaches TIMEOUT (TIMEOUT>0), terminate as REQ-022 with rsp_err=1, rsp_rdata=0; counter cleared on every entry to SETUP.
REQ-024 SHALL give minimum latency: accept at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3; each wait state adds 1.
REQ-025 SHALL hold rsp_valid for exactly one cycle; no backpressure on response; rsp_rdata/rsp_err hold last value otherwise.
REQ-026 SHALL allow back-to-back: new request acceptable in the cycle rsp_valid=1 (state IDLE), so transfers spaced 3 cycles minimum.
REQ-027 SHALL treat PREADY=1 and timeout expiry in the same cycle as normal completion (PREADY wins).
REQ-028 SHALL keep at most one PSEL bit high at any time.

Reset
REQ-029 SHALL, with PRESET=1 at a PCLK edge, force state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout counter 0.
REQ-030 SHALL, on reset mid-transfer, abort without emitting rsp_valid; req_ready=1 on the first cycle after PRESET deasserts.

Verification
REQ-031 SHALL cover zero-wait write: addr 0x0000_1004 (slave 1), wdata 0xDEADBEEF, strb 0xF -> PSEL=0b0010 cycles 1-2, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0.
REQ-032 SHALL cover read with 3 wait states from slave 2 returning 0x12345678 -> rsp_valid at cycle 6, rsp_rdata=0x12345678, PSTRB=0 throughout.
REQ-033 SHALL cover NUM_SLAVES=3, addr 0x0000_3000 -> no PSEL, rsp_valid cycle 2, rsp_err=1, rsp_rdata=0.
REQ-034 SHALL cover TIMEOUT=4, PREADY stuck 0 -> ACCESS lasts 4 cycles, then rsp_err=1, PSEL=0.
REQ-035 SHALL cover PSLVERR=1 with PREADY=1 on slave 0 write -> rsp_err=1; plus PRESET asserted in ACCESS -> no rsp_valid, all outputs 0 next cycle.
